// File: rtl/nes_pad_poller.sv
// Polls NUM_CTRL serial NES/SNES pads at a fixed rate and deserialises them into a pressed-high button vector.
// Optional auto-repeat of held buttons in btn_pressed is built when NES_AUTOREPEAT_EN is defined.
module nes_pad_poller #(
  parameter int NUM_CTRL     = 2,
  parameter int NUM_BITS     = 8,
  parameter int LATCH_CYCLES = 1200,
  parameter int HALF_CYCLES  = 600,
  parameter int POLL_CYCLES  = 1666667,
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_RATE  = 6
) (
  input  logic                         sysclk,
  input  logic                         reset_high,
  input  logic [NUM_CTRL-1:0]          nes_data,
  output logic [NUM_CTRL-1:0]          nes_latch,
  output logic [NUM_CTRL-1:0]          nes_pulse,
  output logic [NUM_CTRL*NUM_BITS-1:0] btn_state,
  output logic                         btn_valid,
  output logic [NUM_CTRL*NUM_BITS-1:0] btn_pressed
);

  localparam int W    = NUM_CTRL * NUM_BITS;
  localparam int PW   = $clog2(POLL_CYCLES + 1);
  localparam int CMAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(NUM_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_SETTLE, S_PULSE_HI, S_PULSE_LO, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       poll_q;
  logic                tick;
  logic [NUM_CTRL-1:0] sync1_q, sync2_q, pressed_now;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [W-1:0]        shift_q, shift_d;
  logic [W-1:0]        btn_state_q, btn_pressed_q, pressed_d;
  logic                cnt_last, sample;
  logic                latch_q, pulse_q, valid_q;
  logic                latch_d, pulse_d, done_d;

  assign tick        = (poll_q == PW'(POLL_CYCLES - 1));
  assign pressed_now = ~sync2_q;

  assign nes_latch   = {NUM_CTRL{latch_q}};
  assign nes_pulse   = {NUM_CTRL{pulse_q}};
  assign btn_state   = btn_state_q;
  assign btn_valid   = valid_q;
  assign btn_pressed = btn_pressed_q;

  always_ff @(posedge sysclk) begin
    if (reset_high) begin
      state_q       <= S_IDLE;
      poll_q        <= '0;
      sync1_q       <= '0;
      sync2_q       <= '0;
      cnt_q         <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      latch_q       <= 1'b0;
      pulse_q       <= 1'b0;
      valid_q       <= 1'b0;
      btn_state_q   <= '0;
      btn_pressed_q <= '0;
    end else begin
      state_q       <= state_d;
      poll_q        <= tick ? '0 : poll_q + PW'(1);
      sync1_q       <= nes_data;
      sync2_q       <= sync1_q;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      latch_q       <= latch_d;
      pulse_q       <= pulse_d;
      valid_q       <= done_d;
      btn_pressed_q <= done_d ? pressed_d : '0;
      if (done_d) btn_state_q <= shift_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_last = (state_q == S_LATCH) ? (cnt_q == CW'(LATCH_CYCLES - 1))
                                    : (cnt_q == CW'(HALF_CYCLES - 1));
    sample   = cnt_last && (state_q == S_SETTLE || state_q == S_PULSE_LO);
    case (state_q)
      S_IDLE:     if (tick) state_d = S_LATCH;
      S_LATCH:    if (cnt_last) state_d = S_SETTLE;
      S_SETTLE:   if (cnt_last) state_d = S_PULSE_HI;
      S_PULSE_HI: if (cnt_last) state_d = S_PULSE_LO;
      S_PULSE_LO: if (cnt_last) state_d = (bit_q == BW'(NUM_BITS - 1)) ? S_DONE : S_PULSE_HI;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    cnt_d = (state_q == S_IDLE || state_d != state_q) ? '0 : cnt_q + CW'(1);
    bit_d = (state_q == S_IDLE) ? '0 : (sample ? bit_q + BW'(1) : bit_q);

    // Shift right so the first bit out of the pad lands at index 0 of each pad slice.
    shift_d = shift_q;
    if (sample) begin
      for (int unsigned c = 0; c < NUM_CTRL; c++) begin
        shift_d[c*NUM_BITS +: NUM_BITS] = {pressed_now[c], shift_q[c*NUM_BITS+1 +: NUM_BITS-1]};
      end
    end
  end

  always_comb begin
    latch_d = (state_d == S_LATCH);
    pulse_d = (state_d == S_PULSE_HI);
    done_d  = (state_d == S_DONE);
  end

`ifdef NES_AUTOREPEAT_EN
  logic [NUM_CTRL-1:0][15:0] rep_q, rep_d;
  logic [31:0]               rk;

  always_ff @(posedge sysclk) begin
    if (reset_high) rep_q <= '0;
    else            rep_q <= rep_d;
  end

  // Repeat decision uses the counter value after this poll's update.
  always_comb begin
    rep_d     = rep_q;
    pressed_d = shift_d & ~btn_state_q;
    rk        = '0;
    if (done_d) begin
      for (int unsigned c = 0; c < NUM_CTRL; c++) begin
        if (shift_d[c*NUM_BITS +: NUM_BITS] != btn_state_q[c*NUM_BITS +: NUM_BITS] ||
            shift_d[c*NUM_BITS +: NUM_BITS] == '0) begin
          rep_d[c] = '0;
        end else if (rep_q[c] != '1) begin
          rep_d[c] = rep_q[c] + 16'd1;
        end
        rk = 32'(rep_d[c]);
        if (rk == 32'(REPEAT_DELAY) ||
            (rk > 32'(REPEAT_DELAY) && ((rk - 32'(REPEAT_DELAY)) % 32'(REPEAT_RATE)) == 32'd0)) begin
          pressed_d[c*NUM_BITS +: NUM_BITS] = pressed_d[c*NUM_BITS +: NUM_BITS] |
                                              shift_d[c*NUM_BITS +: NUM_BITS];
        end
      end
    end
  end
`else
  always_comb begin
    pressed_d = shift_d & ~btn_state_q;
  end
`endif

endmodule

// File: tb/tb_nes_pad_poller.sv
// Directed bench: two instances (2x NES, 1x SNES) driven by behavioural pad models, scoreboard on btn_valid.
module tb_nes_pad_poller;
  localparam int LAT  = 4;
  localparam int HALF = 3;
  localparam int POLL = 100;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic        rst;
  logic [1:0]  d8, latch8, pulse8;
  logic [15:0] st8, pr8;
  logic        v8;
  logic [0:0]  d16, latch16, pulse16;
  logic [15:0] st16, pr16;
  logic        v16;

  nes_pad_poller #(.NUM_CTRL(2), .NUM_BITS(8), .LATCH_CYCLES(LAT), .HALF_CYCLES(HALF),
                   .POLL_CYCLES(POLL), .REPEAT_DELAY(3), .REPEAT_RATE(2)) dut8 (
    .sysclk(sysclk), .reset_high(rst), .nes_data(d8), .nes_latch(latch8), .nes_pulse(pulse8),
    .btn_state(st8), .btn_valid(v8), .btn_pressed(pr8));

  nes_pad_poller #(.NUM_CTRL(1), .NUM_BITS(16), .LATCH_CYCLES(LAT), .HALF_CYCLES(HALF),
                   .POLL_CYCLES(POLL), .REPEAT_DELAY(3), .REPEAT_RATE(2)) dut16 (
    .sysclk(sysclk), .reset_high(rst), .nes_data(d16), .nes_latch(latch16), .nes_pulse(pulse16),
    .btn_state(st16), .btn_valid(v16), .btn_pressed(pr16));

  // Pad models: parallel load while latch high, shift on pulse rising edge, data low = pressed.
  logic [7:0]  btn8 [2];
  logic [7:0]  sh8 [2];
  logic [15:0] btn16, sh16;
  logic [1:0]  pp8 = '0;
  logic        pp16 = 1'b0;

  always @(posedge sysclk) begin
    for (int c = 0; c < 2; c++) begin
      if (rst)                          sh8[c] <= '0;
      else if (latch8[c])               sh8[c] <= btn8[c];
      else if (pulse8[c] && !pp8[c])    sh8[c] <= sh8[c] >> 1;
    end
    if (rst)                            sh16 <= '0;
    else if (latch16[0])                sh16 <= btn16;
    else if (pulse16[0] && !pp16)       sh16 <= sh16 >> 1;
    pp8  <= pulse8;
    pp16 <= pulse16[0];
  end

  assign d8  = {~sh8[1][0], ~sh8[0][0]};
  assign d16 = ~sh16[0];

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  logic        lp8 = 1'b0, lpu8 = 1'b0, lpu16 = 1'b0;
  int          t_latch = 0, lat_hi = 0, p_rise = 0, p_hi = 0, p16_rise = 0, r16_at_valid = 0;
  logic [15:0] st16_at_valid = '0;
  bit          seen16 = 1'b0;
  int          stray = 0;

  always @(negedge sysclk) begin
    lp8   <= latch8[0];
    lpu8  <= pulse8[0];
    lpu16 <= pulse16[0];
    if (latch8[0] && !lp8) begin
      t_latch <= cyc; lat_hi <= 1; p_rise <= 0; p_hi <= 0;
    end else begin
      if (latch8[0]) lat_hi <= lat_hi + 1;
      if (pulse8[0] && !lpu8) p_rise <= p_rise + 1;
      if (pulse8[0]) p_hi <= p_hi + 1;
    end
    if (latch16[0]) p16_rise <= 0;
    else if (pulse16[0] && !lpu16) p16_rise <= p16_rise + 1;
    if (v16 && !seen16) begin
      st16_at_valid <= st16; r16_at_valid <= p16_rise; seen16 <= 1'b1;
    end
    if ((!v8 && pr8 != '0) || (!v16 && pr16 != '0) ||
        latch8[0] != latch8[1] || pulse8[0] != pulse8[1]) stray <= stray + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct { logic [15:0] st; logic [15:0] pr; } exp_t;
  exp_t        sb[$];
  logic [15:0] model_prev = '0;

  task automatic push_exp(input logic [15:0] nw);
    exp_t e;
    e.st = nw;
    e.pr = nw & ~model_prev;
    model_prev = nw;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_state"}, 32'(st8), 32'(e.st));
      chk({tag, "_pressed"}, 32'(pr8), 32'(e.pr));
    end
  endtask

  task automatic wait_valid(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sysclk);
      if (v8 === 1'b1) begin ok = 1'b1; break; end
    end
    chk({tag, "_valid_seen"}, 32'(ok), 32'd1);
  endtask

  int n;
  int p;
  bit prev;

  initial begin
    rst = 1'b1;
    btn8[0] = 8'h01;
    btn8[1] = 8'h08;
    btn16   = 16'h8001;
    repeat (5) @(negedge sysclk);
    chk("rst_latch",   32'(latch8), 32'd0);
    chk("rst_pulse",   32'(pulse8), 32'd0);
    chk("rst_state",   32'(st8),    32'd0);
    chk("rst_valid",   32'(v8),     32'd0);
    chk("rst_pressed", 32'(pr8),    32'd0);
    chk("rst_state16", 32'(st16),   32'd0);

    push_exp({btn8[1], btn8[0]});
    rst = 1'b0;
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge sysclk);
      if (latch8[0] === 1'b1) begin n = i; break; end
    end
    chk("first_latch_delay", 32'(n), 32'd100);
    wait_valid("poll1");
    chk("latch_to_valid", 32'(cyc - t_latch), 32'd49);
    chk("latch_high_cycles", 32'(lat_hi), 32'd4);
    chk("pulse_count", 32'(p_rise), 32'd7);
    chk("pulse_high_cycles", 32'(p_hi), 32'd21);
    pop_check("poll1");

    push_exp({btn8[1], btn8[0]});
    wait_valid("poll2");
    pop_check("poll2_same");

    chk("snes_seen", 32'(seen16), 32'd1);
    chk("snes_state", 32'(st16_at_valid), 32'h8001);
    chk("snes_pulses", 32'(r16_at_valid), 32'd15);

    btn8[0] = 8'h02;
    push_exp({btn8[1], btn8[0]});
    wait_valid("poll3");
    pop_check("poll3_swap");

    // Reset during the third pulse-high phase of the next transaction.
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sysclk);
      if (latch8[0] === 1'b1) begin n = 1; break; end
    end
    chk("midrst_latch_seen", 32'(n), 32'd1);
    n = 0;
    prev = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sysclk);
      if (pulse8[0] === 1'b1 && !prev) n++;
      prev = pulse8[0];
      if (n == 3) break;
    end
    chk("midrst_third_pulse", 32'(n), 32'd3);
    rst = 1'b1;
    @(negedge sysclk);
    chk("midrst_latch",   32'(latch8), 32'd0);
    chk("midrst_pulse",   32'(pulse8), 32'd0);
    chk("midrst_state",   32'(st8),    32'd0);
    chk("midrst_valid",   32'(v8),     32'd0);
    chk("midrst_state16", 32'(st16),   32'd0);
    rst = 1'b0;
    model_prev = '0;
    push_exp({btn8[1], btn8[0]});
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge sysclk);
      if (v8 === 1'b1) begin n = i; break; end
    end
    chk("midrst_first_valid", 32'(n), 32'd149);
    pop_check("midrst_poll");

`ifdef NES_AUTOREPEAT_EN
    btn8[0] = 8'h10;
    btn8[1] = 8'h00;
    for (p = 1; p <= 8; p++) begin
      wait_valid("rep");
      chk($sformatf("rep_poll%0d", p), 32'(pr8),
          (p == 1 || p == 4 || p == 6 || p == 8) ? 32'h0010 : 32'h0000);
    end
    btn8[0] = 8'h00;
    wait_valid("rep_release");
    chk("rep_release_pressed", 32'(pr8), 32'h0000);
    btn8[0] = 8'h10;
    wait_valid("rep_repress");
    chk("rep_repress_pressed", 32'(pr8), 32'h0010);
    wait_valid("rep_repress2");
    chk("rep_repress2_pressed", 32'(pr8), 32'h0000);
`endif

    chk("stray_pulses", 32'(stray), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
